fifo_push_arbiter: RTL and testbench

Round-robin arbiter that shares one FiFo write port among N requesters. Each requester presents a req/data pair. The arbiter grants one owner at a time for a bounded burst of pushes and drives the FiFo's push and din. It sits directly in front of the FiFo; the FiFo's full flag is fed back here as backpressure.

---
 rtl/fifo_push_arbiter_if.sv | 27 ++
 rtl/fifo_push_arbiter.sv | 99 +++++++++
 tb/tb_fifo_push_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fifo_push_arbiter_if.sv
// Requester/FiFo-facing bundle for the push arbiter: request/data in, FiFo push side out.
// master = requesters plus FiFo status; slave = the arbiter itself.
interface fifo_push_arbiter_if #(
  parameter int N = 4,
  parameter int W = 2
);
  localparam int LGN = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   io_req;
  logic [N*W-1:0] io_din;
  logic           io_fifo_full;
  logic [N-1:0]   io_grant;
  logic           io_fifo_push;
  logic [W-1:0]   io_fifo_din;
  logic [LGN-1:0] io_owner;
  logic           io_busy;

  modport master (
    output io_req, io_din, io_fifo_full,
    input  io_grant, io_fifo_push, io_fifo_din, io_owner, io_busy
  );

  modport slave (
    input  io_req, io_din, io_fifo_full,
    output io_grant, io_fifo_push, io_fifo_din, io_owner, io_busy
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FiFo write port among N requesters in bounded bursts.
// Latency: one arbitration bubble, then one push per cycle for up to MAXBURST beats.
// Backpressure: FiFo full stalls the owner's tenure (no push, count holds) without revoking it.
module fifo_push_arbiter #(
  parameter int N        = 4,
  parameter int W        = 2,
  parameter int MAXBURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_push_arbiter_if.slave   bus
);
  localparam int LGN = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] LAST_BEAT = 8'(MAXBURST - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state_q, state_d;
  logic [LGN-1:0] owner_q, owner_d;
  logic [LGN-1:0] ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [LGN-1:0] pick_idx;
  logic [LGN-1:0] scan_idx;
  logic           pick_vld;
  logic           own_req;
  logic           push;
  logic           in_own;

  // Scan from farthest to nearest so the first set request after ptr wins;
  // k == N wraps to ptr itself, giving the last owner lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = N; k >= 1; k--) begin
      scan_idx = ptr_q + LGN'(k);
      if (bus.io_req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign in_own  = (state_q == OWN);
  assign own_req = bus.io_req[owner_q];
  assign push    = in_own && own_req && !bus.io_fifo_full && !reset;

  assign bus.io_fifo_push = push;
  assign bus.io_grant     = push ? (N'(1) << owner_q) : '0;
  assign bus.io_fifo_din  = in_own ? bus.io_din[owner_q*W +: W] : '0;
  assign bus.io_owner     = in_own ? owner_q : '0;
  assign bus.io_busy      = in_own;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWN;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (push) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (!own_req || (push && (cnt_q == LAST_BEAT))) begin
          state_d = IDLE;
          ptr_d   = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  a_no_push_when_full : assert property (@(posedge clk) disable iff (reset)
    !(bus.io_fifo_push && bus.io_fifo_full));
  a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.io_grant));
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed-vector bench for fifo_push_arbiter (N=4, W=2, MAXBURST=4) plus an end-to-end
// run against a behavioural depth-2 FiFo with random pops.
module tb_fifo_push_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_push_arbiter_if #(.N(4), .W(2)) bus ();
  fifo_push_arbiter #(.N(4), .W(2), .MAXBURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [7:0] din;
    logic       full;
    logic [3:0] grant;
    logic       push;
    logic [1:0] fdin;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  task automatic add(input logic rst, input logic [3:0] req, input logic [7:0] din,
                     input logic full, input logic [3:0] grant, input logic push,
                     input logic [1:0] fdin, input logic [1:0] owner, input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.din = din; v.full = full;
    v.grant = grant; v.push = push; v.fdin = fdin; v.owner = owner; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input logic rst, input logic [3:0] req, input logic [7:0] din);
    add(rst, req, din, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0);
  endtask

  logic [1:0] vals [2][3];
  int         idx  [2];
  int         qm[$];
  int         popped;
  bit         ok;
  logic [7:0] d;

  initial begin
    // Reset, then a lone requester 1 (data 3): bubble, 4 beats, bubble, 4 beats.
    add_idle(1'b1, 4'b0000, 8'h00);
    add_idle(1'b1, 4'b0000, 8'h00);
    for (int t = 0; t < 2; t++) begin
      add_idle(1'b0, 4'b0010, 8'h0C);
      for (int b = 0; b < 4; b++) add(1'b0, 4'b0010, 8'h0C, 1'b0, 4'b0010, 1'b1, 2'd3, 2'd1, 1'b1);
    end
    // Re-reset then all four requesting: owners 0,1,2,3,0 with din slice i = i.
    add_idle(1'b1, 4'b1111, 8'hE4);
    for (int t = 0; t < 5; t++) begin
      add_idle(1'b0, 4'b1111, 8'hE4);
      for (int b = 0; b < 4; b++)
        add(1'b0, 4'b1111, 8'hE4, 1'b0, 4'(1 << (t % 4)), 1'b1, 2'(t % 4), 2'(t % 4), 1'b1);
    end
    // Backpressure: owner 2 pushes twice, stalls 3 cycles on full, then 2 more beats.
    add_idle(1'b0, 4'b0100, 8'hE4);
    for (int b = 0; b < 2; b++) add(1'b0, 4'b0100, 8'hE4, 1'b0, 4'b0100, 1'b1, 2'd2, 2'd2, 1'b1);
    for (int b = 0; b < 3; b++) add(1'b0, 4'b0100, 8'hE4, 1'b1, 4'b0000, 1'b0, 2'd2, 2'd2, 1'b1);
    for (int b = 0; b < 2; b++) add(1'b0, 4'b0100, 8'hE4, 1'b0, 4'b0100, 1'b1, 2'd2, 2'd2, 1'b1);
    add_idle(1'b0, 4'b0000, 8'hE4);
    // Early release: owner 0 drops after one beat while req3 waits.
    add_idle(1'b0, 4'b0001, 8'hE4);
    add(1'b0, 4'b1001, 8'hE4, 1'b0, 4'b0001, 1'b1, 2'd0, 2'd0, 1'b1);
    add(1'b0, 4'b1000, 8'hE4, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1);
    add_idle(1'b0, 4'b1000, 8'hE4);
    add(1'b0, 4'b1000, 8'hE4, 1'b0, 4'b1000, 1'b1, 2'd3, 2'd3, 1'b1);
    // Reset mid-burst of owner 1 at cnt=1: no push in the reset cycle, requester 0 next.
    add(1'b0, 4'b0000, 8'hE4, 1'b0, 4'b0000, 1'b0, 2'd3, 2'd3, 1'b1);
    add_idle(1'b0, 4'b0010, 8'hE4);
    add(1'b0, 4'b0010, 8'hE4, 1'b0, 4'b0010, 1'b1, 2'd1, 2'd1, 1'b1);
    add(1'b1, 4'b0010, 8'hE4, 1'b0, 4'b0000, 1'b0, 2'd1, 2'd1, 1'b1);
    add_idle(1'b0, 4'b0011, 8'hE4);
    add(1'b0, 4'b0011, 8'hE4, 1'b0, 4'b0001, 1'b1, 2'd0, 2'd0, 1'b1);
    add(1'b0, 4'b0000, 8'hE4, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1);
    add_idle(1'b0, 4'b0000, 8'hE4);

    bus.io_req = '0;
    bus.io_din = '0;
    bus.io_fifo_full = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      reset            = vecs[i].rst;
      bus.io_req       = vecs[i].req;
      bus.io_din       = vecs[i].din;
      bus.io_fifo_full = vecs[i].full;
      @(negedge clk);
      vec_cnt++;
      if (bus.io_grant !== vecs[i].grant || bus.io_fifo_push !== vecs[i].push ||
          bus.io_fifo_din !== vecs[i].fdin || bus.io_owner !== vecs[i].owner ||
          bus.io_busy !== vecs[i].busy) begin
        miss_cnt++;
        $display("FAIL vec%0d: got grant=%b push=%b din=%0d owner=%0d busy=%b, want grant=%b push=%b din=%0d owner=%0d busy=%b",
                 i, bus.io_grant, bus.io_fifo_push, bus.io_fifo_din, bus.io_owner, bus.io_busy,
                 vecs[i].grant, vecs[i].push, vecs[i].fdin, vecs[i].owner, vecs[i].busy);
      end
    end

    // End-to-end: requesters 0 and 1 each deliver three values into a depth-2 FiFo.
    vals[0][0] = 2'd1; vals[0][1] = 2'd2; vals[0][2] = 2'd3;
    vals[1][0] = 2'd3; vals[1][1] = 2'd0; vals[1][2] = 2'd2;
    idx[0] = 0; idx[1] = 0; popped = 0;
    @(posedge clk); #1;
    reset = 1'b1; bus.io_req = '0; bus.io_din = '0; bus.io_fifo_full = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (idx[0] == 3 && idx[1] == 3 && qm.size() == 0) break;
      @(posedge clk); #1;
      d = '0;
      for (int r = 0; r < 2; r++) begin
        bus.io_req[r] = (idx[r] < 3);
        if (idx[r] < 3) d[r*2 +: 2] = vals[r][idx[r]];
      end
      bus.io_req[3:2]  = 2'b00;
      bus.io_din       = d;
      bus.io_fifo_full = (qm.size() >= 2);
      @(negedge clk);
      ok = 1'b1;
      if (bus.io_fifo_push && bus.io_fifo_full) ok = 1'b0;
      if (bus.io_fifo_push) begin
        if (bus.io_grant == 4'b0001 && idx[0] < 3) ok = ok && (bus.io_fifo_din == vals[0][idx[0]]);
        else if (bus.io_grant == 4'b0010 && idx[1] < 3) ok = ok && (bus.io_fifo_din == vals[1][idx[1]]);
        else ok = 1'b0;
      end else if (bus.io_grant != 4'b0000) begin
        ok = 1'b0;
      end
      vec_cnt++;
      if (!ok) begin
        miss_cnt++;
        $display("FAIL e2e cycle %0d: got push=%b full=%b grant=%b din=%0d, want push only when not full with the granted requester's value (idx %0d/%0d)",
                 c, bus.io_fifo_push, bus.io_fifo_full, bus.io_grant, bus.io_fifo_din, idx[0], idx[1]);
      end
      if ($urandom_range(0, 1) == 1 && qm.size() > 0) begin
        void'(qm.pop_front());
        popped++;
      end
      if (bus.io_fifo_push) begin
        qm.push_back(int'(bus.io_fifo_din));
        if (bus.io_grant[0]) idx[0]++;
        if (bus.io_grant[1]) idx[1]++;
      end
    end
    vec_cnt++;
    if (idx[0] != 3 || idx[1] != 3 || popped != 6) begin
      miss_cnt++;
      $display("FAIL e2e_done: got delivered %0d/%0d popped %0d, want 3/3 popped 6", idx[0], idx[1], popped);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
